// File: rtl/tetris_input_ctrl_if.sv
// Command handshake from the input controller to the tetris core.
// The master side presents cmd_valid and cmd. The slave side answers with cmd_ready.
interface tetris_input_ctrl_if;
    logic       cmd_valid;
    logic [2:0] cmd;
    logic       cmd_ready;

    modport master (output cmd_valid, output cmd, input cmd_ready);
    modport slave  (input cmd_valid, input cmd, output cmd_ready);
endinterface

// File: rtl/tetris_input_ctrl.sv
// Board-button front end for the tetris core. It synchronises, debounces and auto-repeats the buttons,
// generates gravity ticks and issues one game command at a time over a valid/ready handshake.
module tetris_input_ctrl #(
    parameter int DEBOUNCE_CYC = 1000000,
    parameter int DAS_CYC      = 8500000,
    parameter int ARR_CYC      = 2500000,
    parameter int GRAVITY_CYC  = 25000000
) (
    input  logic                clk_50MHz,
    input  logic                reset_n,
    input  logic [3:0]          usr_btn,
    input  logic                game_active,
    output logic [3:0]          btn_level,
    tetris_input_ctrl_if.master cmd_if
);
    localparam int MAX_AB  = (DEBOUNCE_CYC > DAS_CYC) ? DEBOUNCE_CYC : DAS_CYC;
    localparam int MAX_CD  = (ARR_CYC > GRAVITY_CYC) ? ARR_CYC : GRAVITY_CYC;
    localparam int MAX_CYC = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int CW      = $clog2(MAX_CYC);

    localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_CYC - 1);
    localparam logic [CW-1:0] DAS_LAST  = CW'(DAS_CYC - 1);
    localparam logic [CW-1:0] ARR_LAST  = CW'(ARR_CYC - 1);
    localparam logic [CW-1:0] GRAV_LAST = CW'(GRAVITY_CYC - 1);

    localparam logic [2:0] CMD_NONE   = 3'd0;
    localparam logic [2:0] CMD_LEFT   = 3'd1;
    localparam logic [2:0] CMD_RIGHT  = 3'd2;
    localparam logic [2:0] CMD_ROTATE = 3'd3;
    localparam logic [2:0] CMD_DOWN   = 3'd4;

    typedef enum logic {IDLE, ISSUE} state_t;

    state_t          state_q, state_d;
    logic [3:0]      sync1_q, sync1_d, sync2_q, sync2_d;
    logic [3:0]      level_q, level_d;
    logic [CW-1:0]   deb_cnt_q [4];
    logic [CW-1:0]   deb_cnt_d [4];
    logic [CW-1:0]   hold_cnt_q [4];
    logic [CW-1:0]   hold_cnt_d [4];
    logic [3:0]      rep_phase_q, rep_phase_d;
    logic [CW-1:0]   grav_cnt_q, grav_cnt_d;
    logic [3:0]      pend_q, pend_d;
    logic            cmd_valid_q, cmd_valid_d;
    logic [2:0]      cmd_q, cmd_d;

    logic [3:0]      press, repeat_ev, events, pend_set, pend_clr, sel;
    logic [2:0]      sel_cmd;
    logic            grav_tick, down_accept;

    // Pending bits share the button bit order: [3]=left, [2]=rotate, [1]=down, [0]=right.
    always_comb begin
        sync1_d     = usr_btn;
        sync2_d     = sync1_q;
        level_d     = level_q;
        rep_phase_d = '0;
        repeat_ev   = '0;
        for (int i = 0; i < 4; i++) begin
            deb_cnt_d[i]  = '0;
            hold_cnt_d[i] = '0;
            if (sync2_q[i] != level_q[i]) begin
                if (deb_cnt_q[i] == DEB_LAST) begin
                    level_d[i] = ~level_q[i];
                end else begin
                    deb_cnt_d[i] = deb_cnt_q[i] + CW'(1);
                end
            end
            // The first repeat waits DAS; the phase bit then switches every later repeat to ARR.
            if (level_q[i]) begin
                rep_phase_d[i] = rep_phase_q[i];
                if (hold_cnt_q[i] == (rep_phase_q[i] ? ARR_LAST : DAS_LAST)) begin
                    repeat_ev[i]   = 1'b1;
                    rep_phase_d[i] = 1'b1;
                end else begin
                    hold_cnt_d[i] = hold_cnt_q[i] + CW'(1);
                end
            end
        end
        press  = level_d & ~level_q;
        events = press | (repeat_ev & 4'b1011);

        down_accept = (state_q == ISSUE) && cmd_if.cmd_ready && (cmd_q == CMD_DOWN);
        grav_tick   = game_active && (grav_cnt_q == GRAV_LAST);
        if (!game_active || down_accept || grav_tick) begin
            grav_cnt_d = '0;
        end else begin
            grav_cnt_d = grav_cnt_q + CW'(1);
        end
        pend_set = events | {2'b00, grav_tick, 1'b0};

        sel     = '0;
        sel_cmd = CMD_NONE;
        if (pend_q[2]) begin
            sel     = 4'b0100;
            sel_cmd = CMD_ROTATE;
        end else if (pend_q[3]) begin
            sel     = 4'b1000;
            sel_cmd = CMD_LEFT;
        end else if (pend_q[0]) begin
            sel     = 4'b0001;
            sel_cmd = CMD_RIGHT;
        end else if (pend_q[1]) begin
            sel     = 4'b0010;
            sel_cmd = CMD_DOWN;
        end

        state_d     = state_q;
        cmd_valid_d = cmd_valid_q;
        cmd_d       = cmd_q;
        pend_clr    = '0;
        case (state_q)
            IDLE: begin
                if (game_active && (pend_q != '0)) begin
                    state_d     = ISSUE;
                    cmd_valid_d = 1'b1;
                    cmd_d       = sel_cmd;
                    pend_clr    = sel;
                end
            end
            ISSUE: begin
                if (cmd_if.cmd_ready) begin
                    state_d     = IDLE;
                    cmd_valid_d = 1'b0;
                    cmd_d       = CMD_NONE;
                end
            end
        endcase
        // A new event wins over the clear, so a repeat that lands during issue queues another command.
        pend_d = game_active ? ((pend_q & ~pend_clr) | pend_set) : '0;
    end

    always_ff @(posedge clk_50MHz) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            sync1_q     <= '0;
            sync2_q     <= '0;
            level_q     <= '0;
            rep_phase_q <= '0;
            grav_cnt_q  <= '0;
            pend_q      <= '0;
            cmd_valid_q <= 1'b0;
            cmd_q       <= CMD_NONE;
            for (int i = 0; i < 4; i++) begin
                deb_cnt_q[i]  <= '0;
                hold_cnt_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            level_q     <= level_d;
            rep_phase_q <= rep_phase_d;
            grav_cnt_q  <= grav_cnt_d;
            pend_q      <= pend_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_q       <= cmd_d;
            for (int i = 0; i < 4; i++) begin
                deb_cnt_q[i]  <= deb_cnt_d[i];
                hold_cnt_q[i] <= hold_cnt_d[i];
            end
        end
    end

    assign btn_level        = level_q;
    assign cmd_if.cmd_valid = cmd_valid_q;
    assign cmd_if.cmd       = cmd_q;
endmodule

// File: tb/tb_tetris_input_ctrl.sv
// Directed bench for tetris_input_ctrl. Stimulus pushes each expected command with its expected handshake cycle.
// A negedge monitor pops and compares every accepted command against that queue.
module tb_tetris_input_ctrl;
    localparam int DEB  = 4;
    localparam int DAS  = 20;
    localparam int ARR  = 5;
    localparam int GRAV = 50;

    logic       clk_50MHz = 1'b0;
    logic       reset_n;
    logic [3:0] usr_btn;
    logic       game_active;
    logic [3:0] btn_level;

    tetris_input_ctrl_if cmd_if();

    tetris_input_ctrl #(
        .DEBOUNCE_CYC(DEB),
        .DAS_CYC(DAS),
        .ARR_CYC(ARR),
        .GRAVITY_CYC(GRAV)
    ) dut (
        .clk_50MHz(clk_50MHz),
        .reset_n(reset_n),
        .usr_btn(usr_btn),
        .game_active(game_active),
        .btn_level(btn_level),
        .cmd_if(cmd_if)
    );

    always #10 clk_50MHz = ~clk_50MHz;

    int cyc = 0;
    always @(posedge clk_50MHz) cyc <= cyc + 1;

    typedef struct {
        logic [2:0] cmd;
        int         at;
    } exp_t;

    exp_t expq[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   t0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic checkWindow(input string name, input int actual, input int lo, input int hi);
        checks++;
        if (actual < lo || actual > hi) begin
            errors++;
            $display("[TB] FAIL %s: got cycle %0d expected %0d..%0d", name, actual, lo, hi);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] btn, input logic active, input logic ready);
        usr_btn          = btn;
        game_active      = active;
        cmd_if.cmd_ready = ready;
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk_50MHz);
        #1;
    endtask

    task automatic expectCmd(input logic [2:0] c, input int at);
        exp_t e;
        e.cmd = c;
        e.at  = at;
        expq.push_back(e);
    endtask

    // Every accepted command must match the next queued expectation in code and timing.
    always @(negedge clk_50MHz) begin
        if (reset_n && cmd_if.cmd_valid && cmd_if.cmd_ready) begin
            if (expq.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_cmd: got cmd %0d at cycle %0d, expected none", cmd_if.cmd, cyc);
            end else begin
                mon_e = expq.pop_front();
                checkOutput("cmd_code", {29'd0, cmd_if.cmd}, {29'd0, mon_e.cmd});
                checkWindow("cmd_cycle", cyc, mon_e.at - 1, mon_e.at + 1);
            end
        end
    end

    initial begin
        reset_n = 1'b0;
        applyStimulus(4'b0000, 1'b0, 1'b1);
        waitCycles(3);
        checkOutput("reset_valid", {31'd0, cmd_if.cmd_valid}, 32'd0);
        checkOutput("reset_cmd", {29'd0, cmd_if.cmd}, 32'd0);
        checkOutput("reset_level", {28'd0, btn_level}, 32'd0);
        reset_n = 1'b1;
        waitCycles(5);

        // Bounce on rotate, then a steady press held for 60 cycles: one ROTATE plus one gravity DOWN.
        t0 = cyc;
        game_active = 1'b1;
        for (int i = 0; i < 10; i++) begin
            usr_btn[2] = (i % 2 == 0);
            waitCycles(2);
        end
        usr_btn[2] = 1'b1;
        expectCmd(3'd3, t0 + 27);
        expectCmd(3'd4, t0 + 51);
        waitCycles(5);
        checkOutput("bounce_level_early", {31'd0, btn_level[2]}, 32'd0);
        waitCycles(1);
        checkOutput("bounce_level_rise", {31'd0, btn_level[2]}, 32'd1);
        waitCycles(54);
        usr_btn[2] = 1'b0;
        waitCycles(10);
        game_active = 1'b0;
        waitCycles(10);

        // Left held: press, first repeat after DAS, then every ARR, with one gravity DOWN in the middle.
        t0 = cyc;
        applyStimulus(4'b1000, 1'b1, 1'b1);
        expectCmd(3'd1, t0 + 7);
        expectCmd(3'd1, t0 + 27);
        expectCmd(3'd1, t0 + 32);
        expectCmd(3'd1, t0 + 37);
        expectCmd(3'd1, t0 + 42);
        expectCmd(3'd1, t0 + 47);
        expectCmd(3'd4, t0 + 51);
        expectCmd(3'd1, t0 + 53);
        expectCmd(3'd1, t0 + 57);
        waitCycles(52);
        usr_btn = 4'b0000;
        waitCycles(18);
        game_active = 1'b0;
        waitCycles(10);

        // Backpressure: RIGHT must stay valid and stable for 30 cycles while ready is low.
        t0 = cyc;
        applyStimulus(4'b0001, 1'b1, 1'b0);
        expectCmd(3'd2, t0 + 37);
        expectCmd(3'd4, t0 + 51);
        waitCycles(7);
        for (int k = 0; k < 30; k++) begin
            checkOutput("bp_valid", {31'd0, cmd_if.cmd_valid}, 32'd1);
            checkOutput("bp_cmd", {29'd0, cmd_if.cmd}, 32'd2);
            if (k == 1) usr_btn = 4'b0000;
            waitCycles(1);
        end
        cmd_if.cmd_ready = 1'b1;
        waitCycles(18);
        game_active = 1'b0;
        waitCycles(10);

        // Priority ROTATE > LEFT > RIGHT; a second right press while stalled coalesces.
        t0 = cyc;
        applyStimulus(4'b1101, 1'b1, 1'b0);
        expectCmd(3'd3, t0 + 30);
        expectCmd(3'd1, t0 + 32);
        expectCmd(3'd2, t0 + 34);
        expectCmd(3'd4, t0 + 51);
        waitCycles(8);
        usr_btn = 4'b0000;
        waitCycles(8);
        usr_btn[0] = 1'b1;
        waitCycles(8);
        usr_btn[0] = 1'b0;
        waitCycles(6);
        cmd_if.cmd_ready = 1'b1;
        waitCycles(25);
        game_active = 1'b0;
        waitCycles(10);

        // Gravity alone. Each accepted DOWN restarts the period.
        t0 = cyc;
        game_active = 1'b1;
        expectCmd(3'd4, t0 + 51);
        expectCmd(3'd4, t0 + 103);
        expectCmd(3'd4, t0 + 155);
        waitCycles(160);
        game_active = 1'b0;
        waitCycles(10);

        // A soft drop accepted at +70 pushes the next gravity DOWN out to +122.
        t0 = cyc;
        game_active = 1'b1;
        expectCmd(3'd4, t0 + 51);
        expectCmd(3'd4, t0 + 70);
        expectCmd(3'd4, t0 + 122);
        waitCycles(63);
        usr_btn[1] = 1'b1;
        waitCycles(12);
        usr_btn[1] = 1'b0;
        waitCycles(55);
        game_active = 1'b0;
        waitCycles(10);

        // The soft drop is pending when game_active drops, so it is discarded.
        t0 = cyc;
        applyStimulus(4'b0010, 1'b1, 1'b1);
        waitCycles(6);
        game_active = 1'b0;
        waitCycles(2);
        usr_btn = 4'b0000;
        waitCycles(100);
        // The gravity counter restarts from zero on reactivation.
        t0 = cyc;
        game_active = 1'b1;
        expectCmd(3'd4, t0 + 51);
        waitCycles(55);
        game_active = 1'b0;
        waitCycles(10);

        // Reset arrives during ISSUE: valid drops at once and nothing is replayed.
        applyStimulus(4'b1000, 1'b1, 1'b0);
        waitCycles(7);
        checkOutput("issue_valid", {31'd0, cmd_if.cmd_valid}, 32'd1);
        checkOutput("issue_cmd", {29'd0, cmd_if.cmd}, 32'd1);
        waitCycles(1);
        reset_n = 1'b0;
        applyStimulus(4'b0000, 1'b0, 1'b0);
        waitCycles(1);
        checkOutput("rst_mid_valid", {31'd0, cmd_if.cmd_valid}, 32'd0);
        checkOutput("rst_mid_cmd", {29'd0, cmd_if.cmd}, 32'd0);
        checkOutput("rst_mid_level", {28'd0, btn_level}, 32'd0);
        reset_n = 1'b1;
        cmd_if.cmd_ready = 1'b1;
        waitCycles(20);

        checks++;
        if (expq.size() != 0) begin
            errors++;
            $display("[TB] FAIL missing_cmds: got %0d outstanding expected 0", expq.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
